// File: rtl/dip_pkg.sv
// Shared definitions for the DIP switch controller: register offsets,
// debounce FSM encoding and the PERIOD field width.
package dip_pkg;

   localparam int PERIOD_W = 20;

   localparam logic [31:0] OFF_DATA0  = 32'h00;
   localparam logic [31:0] OFF_DATA1  = 32'h04;
   localparam logic [31:0] OFF_CTRL   = 32'h08;
   localparam logic [31:0] OFF_PERIOD = 32'h0C;
   localparam logic [31:0] OFF_STATUS = 32'h10;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   // A programmed period of zero behaves like one cycle.
   function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
      return (p == '0) ? PERIOD_W'(1) : p;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, with a
// configurable reset value.
module sync2 #(
   parameter int               WIDTH   = 64,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage1_reg;
   logic [WIDTH-1:0] stage2_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         stage1_reg <= RST_VAL;
         stage2_reg <= RST_VAL;
      end else begin
         stage1_reg <= d;
         stage2_reg <= stage1_reg;
      end
   end

   assign q = stage2_reg;

endmodule

// File: rtl/dip_switch_ctrl.sv
// Memory-mapped controller for eight active-low DIP switch banks: synchronizes,
// debounces with a programmable period and raises a change interrupt.
module dip_switch_ctrl
   import dip_pkg::*;
#(
   parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 20'd100000,
   parameter logic [31:0]         BASE           = 32'h7f60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   input  logic [7:0]  switch0,
   input  logic [7:0]  switch1,
   input  logic [7:0]  switch2,
   input  logic [7:0]  switch3,
   input  logic [7:0]  switch4,
   input  logic [7:0]  switch5,
   input  logic [7:0]  switch6,
   input  logic [7:0]  switch7,
   output logic [31:0] Dout,
   output logic        IRQ
);

   logic [63:0] raw;
   logic [63:0] sync;

   state_t              state_reg,  state_next;
   logic [63:0]         stable_reg, stable_next;
   logic [63:0]         cand_reg,   cand_next;
   logic [PERIOD_W-1:0] cnt_reg,    cnt_next;
   logic                commit;

   logic                ie_reg;
   logic                chg_reg;
   logic [PERIOD_W-1:0] period_reg;
   logic [PERIOD_W-1:0] period_m1;

   logic sel_data0, sel_data1, sel_ctrl, sel_period, sel_status;
   logic wr_ctrl, wr_period, wr_status;
   logic unused_din;

   assign raw = {switch7, switch6, switch5, switch4, switch3, switch2, switch1, switch0};

   sync2 #(
      .WIDTH   (64),
      .RST_VAL ({64{1'b1}})
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (raw),
      .q     (sync)
   );

   assign sel_data0  = (Addr == BASE + OFF_DATA0);
   assign sel_data1  = (Addr == BASE + OFF_DATA1);
   assign sel_ctrl   = (Addr == BASE + OFF_CTRL);
   assign sel_period = (Addr == BASE + OFF_PERIOD);
   assign sel_status = (Addr == BASE + OFF_STATUS);

   assign wr_ctrl   = WE & sel_ctrl;
   assign wr_period = WE & sel_period;
   assign wr_status = WE & sel_status;
   assign unused_din = ^Din[31:PERIOD_W];

   // Compare uses the live PERIOD so a mid-count write takes effect at once.
   assign period_m1 = eff_period(period_reg) - PERIOD_W'(1);

   always_comb begin
      state_next  = state_reg;
      stable_next = stable_reg;
      cand_next   = cand_reg;
      cnt_next    = cnt_reg;
      commit      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (sync != stable_reg) begin
               cand_next  = sync;
               cnt_next   = '0;
               state_next = COUNT;
            end
         end
         COUNT: begin
            if (sync == stable_reg) begin
               state_next = IDLE;
            end else if (sync != cand_reg) begin
               cand_next = sync;
               cnt_next  = '0;
            end else if (cnt_reg >= period_m1) begin
               stable_next = cand_reg;
               commit      = 1'b1;
               state_next  = IDLE;
            end else if (cnt_reg != '1) begin
               cnt_next = cnt_reg + PERIOD_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         stable_reg <= '1;
         cand_reg   <= '1;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         stable_reg <= stable_next;
         cand_reg   <= cand_next;
         cnt_reg    <= cnt_next;
      end
   end

   // A commit setting CHG takes priority over a same-cycle W1C.
   always_ff @(posedge clk) begin
      if (reset) begin
         ie_reg     <= 1'b0;
         chg_reg    <= 1'b0;
         period_reg <= DEFAULT_PERIOD;
      end else begin
         if (wr_ctrl)
            ie_reg <= Din[0];
         if (wr_period)
            period_reg <= Din[PERIOD_W-1:0];
         if (commit)
            chg_reg <= 1'b1;
         else if (wr_status && Din[0])
            chg_reg <= 1'b0;
      end
   end

   always_comb begin
      Dout = '0;
      if (sel_data0)
         Dout = ~stable_reg[31:0];
      else if (sel_data1)
         Dout = ~stable_reg[63:32];
      else if (sel_ctrl)
         Dout = {31'd0, ie_reg};
      else if (sel_period)
         Dout = {{(32-PERIOD_W){1'b0}}, period_reg};
      else if (sel_status)
         Dout = {31'd0, chg_reg};
   end

   assign IRQ = chg_reg & ie_reg;

endmodule
